dmem_responder: RTL and testbench

//  Multi-cycle data-memory responder: the memory side of the CPU data-access interface.

---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_lane_unit.sv | 77 +++++++
 rtl/dmem_responder.sv | 137 +++++++++++++
 tb/tb_dmem_responder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder.
//   SZ_*      : request size encodings (3 is reserved and treated as a word)
//   state_e   : responder FSM states
//   *_W       : datapath and wait-counter widths
package dmem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_lane_unit.sv
// Combinational lane logic for one access against one storage word.
//   addr_i         : byte address of the access
//   size_i         : SZ_BYTE / SZ_HALF / SZ_WORD (3 treated as word)
//   unsigned_i     : load zero-extends when set, sign-extends otherwise
//   wdata_i        : right-justified store data
//   word_i         : current contents of the addressed storage word
//   err_addr_o     : last byte of the access lies beyond the storage
//   err_misalign_o : half at odd address or word not on a 4-byte boundary
//   be_o           : big-endian byte enables (bit 3 = bits [31:24])
//   wword_o        : word_i with the store data inserted in the enabled lanes
//   rdata_o        : extracted and extended load data
module dmem_lane_unit
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [DATA_W-1:0] word_i,
    output logic              err_addr_o,
    output logic              err_misalign_o,
    output logic [3:0]        be_o,
    output logic [DATA_W-1:0] wword_o,
    output logic [DATA_W-1:0] rdata_o
);

    localparam logic [ADDR_W:0] LastByte = (ADDR_W+1)'(DEPTH_WORDS * 4) - 1'b1;

    logic [1:0]        off;
    logic [ADDR_W:0]   nbytes;
    logic [ADDR_W:0]   last_byte;
    logic [DATA_W-1:0] rep;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] shifted;

    assign off = addr_i[1:0];

    always_comb begin
        nbytes         = (ADDR_W+1)'(4);
        rep            = wdata_i;
        be_o           = 4'b1111;
        err_misalign_o = 1'b0;
        rdata_o        = word_i;
        // Left-align the addressed lane so byte/half extraction reads the top bits.
        shifted        = word_i << {off, 3'b000};
        case (size_i)
            SZ_BYTE: begin
                nbytes  = (ADDR_W+1)'(1);
                rep     = {4{wdata_i[7:0]}};
                be_o    = 4'b1000 >> off;
                rdata_o = unsigned_i ? {24'b0, shifted[31:24]}
                                     : {{24{shifted[31]}}, shifted[31:24]};
            end
            SZ_HALF: begin
                nbytes         = (ADDR_W+1)'(2);
                rep            = {2{wdata_i[15:0]}};
                be_o           = off[1] ? 4'b0011 : 4'b1100;
                err_misalign_o = off[0];
                rdata_o        = unsigned_i ? {16'b0, shifted[31:16]}
                                            : {{16{shifted[31]}}, shifted[31:16]};
            end
            default: begin
                err_misalign_o = (off != 2'b00);
            end
        endcase
    end

    // 33-bit sum so addresses near 2^32 cannot wrap back into range.
    assign last_byte  = {1'b0, addr_i} + nbytes - 1'b1;
    assign err_addr_o = (last_byte > LastByte);

    assign mask    = {{8{be_o[3]}}, {8{be_o[2]}}, {8{be_o[1]}}, {8{be_o[0]}}};
    assign wword_o = (word_i & ~mask) | (rep & mask);

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with a valid/ready request and response channel.
//   clk_i, rst_i       : clock and asynchronous active-low reset (also clears storage)
//   req_valid_i/_ready_o, req_write_i, req_addr_i, req_wdata_i, req_size_i,
//   req_unsigned_i     : request channel, sampled only while idle
//   rsp_valid_o/_ready_i, rsp_rdata_o, rsp_err_addr_o, rsp_err_misalign_o
//                      : response channel, held stable until accepted
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_addr_o,
    output logic              rsp_err_misalign_o
);

    localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              write_q, unsigned_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_addr_q, err_mis_q;
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    logic              accept, commit;
    logic [IdxW-1:0]   idx;
    logic [DATA_W-1:0] rd_word, wword, lane_rdata;
    logic [3:0]        be;
    logic              err_addr, err_mis, err_any;

    assign idx     = addr_q[IdxW+1:2];
    assign rd_word = ({{(32-IdxW){1'b0}}, idx} < DEPTH_WORDS) ? mem_q[idx] : '0;
    assign err_any = err_addr | err_mis;

    dmem_lane_unit #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_lane (
        .addr_i         (addr_q),
        .size_i         (size_q),
        .unsigned_i     (unsigned_q),
        .wdata_i        (wdata_q),
        .word_i         (rd_word),
        .err_addr_o     (err_addr),
        .err_misalign_o (err_mis),
        .be_o           (be),
        .wword_o        (wword),
        .rdata_o        (lane_rdata)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (req_valid_i) state_d = StWait;
            StWait:  if (cnt_q == '0) state_d = StResp;
            StResp:  if (rsp_ready_i) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        req_ready_o = (state_q == StIdle);
        rsp_valid_o = (state_q == StResp);
        accept      = (state_q == StIdle) && req_valid_i;
        commit      = (state_q == StWait) && (cnt_q == '0);
    end

    // Request latch, wait counter and response registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q      <= '0;
            write_q    <= 1'b0;
            unsigned_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= SZ_BYTE;
            rdata_q    <= '0;
            err_addr_q <= 1'b0;
            err_mis_q  <= 1'b0;
        end else if (accept) begin
            cnt_q      <= CNT_W'(LATENCY);
            write_q    <= req_write_i;
            unsigned_q <= req_unsigned_i;
            addr_q     <= req_addr_i;
            wdata_q    <= req_wdata_i;
            size_q     <= req_size_i;
        end else if (commit) begin
            rdata_q    <= (write_q || err_any) ? '0 : lane_rdata;
            err_addr_q <= err_addr;
            err_mis_q  <= err_mis;
        end else if (state_q == StWait) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Storage: only a clean store writes, and only at the commit edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem_q[i] <= '0;
            end
        end else if (commit && write_q && !err_any && (be != 4'b0000)) begin
            mem_q[idx] <= wword;
        end
    end

    assign rsp_rdata_o        = rdata_q;
    assign rsp_err_addr_o     = err_addr_q;
    assign rsp_err_misalign_o = err_mis_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed cases plus randomized traffic
// compared against a byte-array reference model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;
    localparam int unsigned BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err_addr, rsp_err_mis;
    logic [31:0] rsp_rdata;

    logic [7:0]  ref_mem [BYTES];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst_n),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_write_i        (req_write),
        .req_addr_i         (req_addr),
        .req_wdata_i        (req_wdata),
        .req_size_i         (req_size),
        .req_unsigned_i     (req_unsigned),
        .rsp_valid_o        (rsp_valid),
        .rsp_ready_i        (rsp_ready),
        .rsp_rdata_o        (rsp_rdata),
        .rsp_err_addr_o     (rsp_err_addr),
        .rsp_err_misalign_o (rsp_err_mis)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(BYTES); i++) ref_mem[i] = 8'h00;
    endtask

    // Reference: byte-level big-endian memory, errors from plain arithmetic.
    task automatic model(input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic u,
                         output logic [31:0] rd, output logic ea, output logic em);
        longint unsigned n, last, v;
        n    = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        last = longint'(a) + n - 1;
        ea   = (last > longint'(BYTES - 1));
        em   = (n == 2 && a % 2 != 0) || (n == 4 && a % 4 != 0);
        rd   = 32'h0;
        if (ea || em) return;
        if (w) begin
            for (longint unsigned i = 0; i < n; i++)
                ref_mem[a + 32'(i)] = 8'((longint'(wd) >> (8 * (n - 1 - i))) & 255);
        end else begin
            v = 0;
            for (longint unsigned i = 0; i < n; i++) v = v * 256 + longint'(ref_mem[a + 32'(i)]);
            if (!u && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v + 64'hFFFF_FFFF_0000_0000
                                                                     - (longint'(1) << (8 * n))
                                                                     + 64'h1_0000_0000;
            rd = v[31:0];
        end
    endtask

    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic u, input int hold,
                        input string tag);
        logic [31:0] erd;
        logic        eea, eem;
        int          lat;
        model(w, a, wd, sz, u, erd, eea, eem);
        @(negedge clk);
        check({tag, ":req_ready"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd;
        req_size = sz; req_unsigned = u;
        @(negedge clk);
        // Inputs must be ignored once the request has been taken.
        req_valid = 1'b0; req_write = ~w; req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom); req_unsigned = ~u;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ":latency"}, 32'(lat), 32'(LAT + 1));
        check({tag, ":rdata"}, rsp_rdata, erd);
        check({tag, ":err_addr"}, {31'b0, rsp_err_addr}, {31'b0, eea});
        check({tag, ":err_mis"}, {31'b0, rsp_err_mis}, {31'b0, eem});
        check({tag, ":busy"}, {31'b0, req_ready}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ":hold_valid"}, {31'b0, rsp_valid}, 32'd1);
            check({tag, ":hold_rdata"}, rsp_rdata, erd);
            check({tag, ":hold_flags"}, {30'b0, rsp_err_addr, rsp_err_mis}, {30'b0, eea, eem});
            check({tag, ":hold_busy"}, {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, ":rsp_drop"}, {31'b0, rsp_valid}, 32'd0);
        check({tag, ":idle"}, {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_size = 2'd0; req_unsigned = 1'b0; rsp_ready = 1'b0;
        clear_model();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset:req_ready", {31'b0, req_ready}, 32'd1);
        check("reset:rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset:rdata", rsp_rdata, 32'd0);
        check("reset:flags", {30'b0, rsp_err_addr, rsp_err_mis}, 32'd0);
        rst_n = 1'b1;

        // Directed cases
        xact(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 0, "st_word");
        xact(1'b0, 32'h10, 32'h0, 2'd2, 1'b1, 0, "ld_word");
        check("ld_word_const", rsp_rdata, 32'hDEADBEEF);
        xact(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 0, "ld_byte_s");
        xact(1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 0, "ld_byte_u");
        xact(1'b0, 32'h10, 32'h0, 2'd1, 1'b0, 0, "ld_half_s");
        xact(1'b1, 32'h11, 32'h55, 2'd0, 1'b0, 0, "st_byte");
        xact(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, "ld_partial");
        xact(1'b1, 32'h22, 32'h1, 2'd2, 1'b0, 0, "st_misalign");
        xact(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, "ld_after_mis");
        xact(1'b0, 32'h3FF, 32'h0, 2'd1, 1'b0, 0, "ld_half_ovf");
        xact(1'b0, 32'hFFFF_FFFC, 32'h0, 2'd2, 1'b0, 0, "ld_word_wrap");
        xact(1'b1, 32'h3FE, 32'hA5C3, 2'd1, 1'b0, 0, "st_half_top");
        xact(1'b0, 32'h3FC, 32'h0, 2'd3, 1'b0, 5, "ld_backpress");

        // Reset while a store waits: nothing is written and storage is cleared.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40;
        req_wdata = 32'h12345678; req_size = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst:req_ready", {31'b0, req_ready}, 32'd1);
        check("midrst:rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("midrst:rdata", rsp_rdata, 32'd0);
        check("midrst:flags", {30'b0, rsp_err_addr, rsp_err_mis}, 32'd0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        xact(1'b0, 32'h40, 32'h0, 2'd2, 1'b0, 0, "ld_after_rst");
        xact(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, "ld_cleared");

        // Randomized traffic
        for (int t = 0; t < 160; t++) begin
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) a = $urandom;
            else a = 32'($urandom_range(0, BYTES + 8));
            if ($urandom_range(0, 9) < 7) begin
                if (sz == 2'd1) a = a & ~32'h1;
                else if (sz != 2'd0) a = a & ~32'h3;
            end
            xact(1'($urandom), a, $urandom, sz, 1'($urandom), int'($urandom_range(0, 2)),
                 "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
